// File: rtl/onewire_temp_slave.sv
// DS18B20-style 1-Wire responder: reset/presence, Skip ROM, Convert T, Read Scratchpad with live CRC8.
// DQ seen through a 2-FF synchroniser; all slot timing in us ticks; the master paces every slot.
module onewire_temp_slave #(
  parameter int FCLK      = 125,
  parameter int T_RST_MIN = 400,
  parameter int T_PD_WAIT = 30,
  parameter int T_PRES    = 120,
  parameter int T_SAMPLE  = 30,
  parameter int T_RD_HOLD = 30,
  parameter int CONV_US   = 750
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dq_in,
  output logic        dq_oe,
  input  logic [15:0] temp_in,
  output logic        conv_busy,
  output logic [7:0]  rx_byte,
  output logic        rx_valid,
  output logic        presence,
  output logic        cmd_err
);
  localparam int CW = (FCLK > 1) ? $clog2(FCLK) : 1;
  localparam int UW = $clog2(CONV_US + T_RST_MIN + T_PRES + 2);
  localparam logic [CW-1:0] C1         = CW'(1);
  localparam logic [CW-1:0] US_LAST    = CW'(FCLK - 1);
  localparam logic [UW-1:0] U1         = UW'(1);
  localparam logic [UW-1:0] RST_MIN    = UW'(T_RST_MIN);
  localparam logic [UW-1:0] PDW_LAST   = UW'(T_PD_WAIT - 1);
  localparam logic [UW-1:0] PRES_LAST  = UW'(T_PRES - 1);
  localparam logic [UW-1:0] SAMP_LAST  = UW'(T_SAMPLE - 1);
  localparam logic [UW-1:0] HOLD_LAST  = UW'(T_RD_HOLD - 1);
  localparam logic [UW-1:0] CONV_LAST  = UW'(CONV_US - 1);

  typedef enum logic [2:0] {IDLE, PD_WAIT, PRESENCE, ROM_RX, FUNC_RX, CONV, TX_SCR} state_t;

  state_t          state;
  logic [CW-1:0]   us_cnt;
  logic            dq_s1, dq_s2, dq_prev;
  logic [UW-1:0]   low_us, slot_us, tmr, conv_us;
  logic            slot_act, holding;
  logic [6:0]      bit_cnt;
  logic [7:0]      rx_sh, crc;
  logic [15:0]     temp_reg;

  logic        tick, fall, rise, bus_rst, tx_bit, fb;
  logic [63:0] scr;
  logic [7:0]  rx_next, crc_next;

  assign tick     = (us_cnt == US_LAST);
  assign fall     = dq_prev & ~dq_s2;
  assign rise     = ~dq_prev & dq_s2;
  assign bus_rst  = rise & (low_us == RST_MIN) & ~dq_oe;
  assign scr      = {8'h10, 8'h0C, 8'hFF, 8'h7F, 8'h46, 8'h4B, temp_reg};
  // Bits 64..71 are the CRC byte, frozen once the 64 data bits have gone out.
  assign tx_bit   = bit_cnt[6] ? crc[bit_cnt[2:0]] : scr[bit_cnt[5:0]];
  assign fb       = crc[0] ^ tx_bit;
  assign crc_next = {1'b0, crc[7:1]} ^ (fb ? 8'h8C : 8'h00);
  assign rx_next  = {dq_s2, rx_sh[7:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      us_cnt    <= '0;
      dq_s1     <= 1'b1;
      dq_s2     <= 1'b1;
      dq_prev   <= 1'b1;
      low_us    <= '0;
      slot_us   <= '0;
      tmr       <= '0;
      conv_us   <= '0;
      slot_act  <= 1'b0;
      holding   <= 1'b0;
      bit_cnt   <= '0;
      rx_sh     <= '0;
      crc       <= '0;
      temp_reg  <= 16'h0550;
      dq_oe     <= 1'b0;
      conv_busy <= 1'b0;
      rx_byte   <= '0;
      rx_valid  <= 1'b0;
      presence  <= 1'b0;
      cmd_err   <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      presence <= 1'b0;
      cmd_err  <= 1'b0;
      dq_s1    <= dq_in;
      dq_s2    <= dq_s1;
      dq_prev  <= dq_s2;
      us_cnt   <= tick ? '0 : us_cnt + C1;

      if (fall)
        low_us <= '0;
      else if (tick && !dq_s2 && low_us != RST_MIN)
        low_us <= low_us + U1;

      // Conversion runs independently of bus activity, including bus resets.
      if (conv_busy && tick) begin
        if (conv_us == CONV_LAST) begin
          conv_busy <= 1'b0;
          temp_reg  <= temp_in;
        end else begin
          conv_us <= conv_us + U1;
        end
      end

      if (holding && tick) begin
        if (tmr == HOLD_LAST) begin
          holding <= 1'b0;
          dq_oe   <= 1'b0;
        end else begin
          tmr <= tmr + U1;
        end
      end

      if (bus_rst) begin
        state    <= PD_WAIT;
        tmr      <= '0;
        bit_cnt  <= '0;
        slot_act <= 1'b0;
        holding  <= 1'b0;
        dq_oe    <= 1'b0;
      end else begin
        case (state)
          IDLE: ;
          PD_WAIT: if (tick) begin
            if (tmr == PDW_LAST) begin
              state    <= PRESENCE;
              dq_oe    <= 1'b1;
              presence <= 1'b1;
              tmr      <= '0;
            end else begin
              tmr <= tmr + U1;
            end
          end
          PRESENCE: if (tick) begin
            if (tmr == PRES_LAST) begin
              dq_oe <= 1'b0;
              state <= ROM_RX;
            end else begin
              tmr <= tmr + U1;
            end
          end
          ROM_RX, FUNC_RX: begin
            if (fall && !dq_oe) begin
              slot_act <= 1'b1;
              slot_us  <= '0;
            end else if (slot_act && tick) begin
              if (slot_us == SAMP_LAST) begin
                slot_act <= 1'b0;
                rx_sh    <= rx_next;
                bit_cnt  <= bit_cnt + 7'd1;
                if (bit_cnt[2:0] == 3'd7) begin
                  rx_byte  <= rx_next;
                  rx_valid <= 1'b1;
                  bit_cnt  <= '0;
                  if (state == ROM_RX) begin
                    if (rx_next == 8'hCC) state <= FUNC_RX;
                    else begin
                      cmd_err <= 1'b1;
                      state   <= IDLE;
                    end
                  end else if (rx_next == 8'h44) begin
                    conv_busy <= 1'b1;
                    conv_us   <= '0;
                    state     <= CONV;
                  end else if (rx_next == 8'hBE) begin
                    crc   <= '0;
                    state <= TX_SCR;
                  end else begin
                    cmd_err <= 1'b1;
                    state   <= IDLE;
                  end
                end
              end else begin
                slot_us <= slot_us + U1;
              end
            end
          end
          CONV: if (fall && !dq_oe && conv_busy) begin
            dq_oe   <= 1'b1;
            holding <= 1'b1;
            tmr     <= '0;
          end
          TX_SCR: if (fall && !dq_oe) begin
            if (!tx_bit) begin
              dq_oe   <= 1'b1;
              holding <= 1'b1;
              tmr     <= '0;
            end
            if (!bit_cnt[6]) crc <= crc_next;
            bit_cnt <= bit_cnt + 7'd1;
            if (bit_cnt == 7'd71) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_onewire_temp_slave.sv
// Directed bench: acts as the 1-Wire master on an open-drain DQ, FCLK shrunk to keep runs short.
module tb_onewire_temp_slave;
  localparam int FCLK = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m_low = 1'b0;
  logic [15:0] temp_in = 16'h0000;
  logic        dq, dq_oe, conv_busy, rx_valid, presence, cmd_err;
  logic [7:0]  rx_byte;

  assign dq = !(m_low || dq_oe);
  always #5 clk = ~clk;

  onewire_temp_slave #(.FCLK(FCLK)) dut (
    .clk(clk), .rst_n(rst_n), .dq_in(dq), .dq_oe(dq_oe), .temp_in(temp_in),
    .conv_busy(conv_busy), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .presence(presence), .cmd_err(cmd_err)
  );

  int n_chk = 0, n_pass = 0;
  int pres_cnt = 0, err_cnt = 0, rxv_cnt = 0, oe_cyc = 0;
  logic [7:0] rx_log0 = 8'h00, rx_log1 = 8'h00;

  always @(negedge clk) begin
    if (presence) pres_cnt++;
    if (cmd_err) err_cnt++;
    if (dq_oe) oe_cyc++;
    if (rx_valid) begin
      rx_log1 = rx_log0;
      rx_log0 = rx_byte;
      rxv_cnt++;
    end
  end

  typedef struct {
    int         rst_us;
    int         nwr;
    logic [7:0] wr0;
    logic [7:0] wr1;
    int         exp_pres;
    int         exp_err;
    int         exp_rxv;
    logic [7:0] exp_rx;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic wait_us(input int n);
    repeat (n * FCLK) @(negedge clk);
  endtask

  task automatic bus_reset(input int len);
    m_low = 1'b1;
    wait_us(len);
    m_low = 1'b0;
  endtask

  task automatic reset_presence();
    bus_reset(480);
    wait_us(160);
  endtask

  task automatic write_bit(input logic b);
    m_low = 1'b1;
    wait_us(b ? 5 : 60);
    m_low = 1'b0;
    wait_us(b ? 65 : 10);
  endtask

  task automatic write_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) write_bit(v[i]);
  endtask

  task automatic read_bit(output logic b);
    m_low = 1'b1;
    wait_us(2);
    m_low = 1'b0;
    wait_us(13);
    b = dq;
    wait_us(55);
  endtask

  task automatic read_byte(output logic [7:0] v);
    logic b;
    v = 8'h00;
    for (int i = 0; i < 8; i++) begin
      read_bit(b);
      v[i] = b;
    end
  endtask

  initial begin
    vec_t       tbl [5];
    logic [7:0] scr_exp [9];
    logic [7:0] rb;
    logic       b;
    int         p0, e0, r0, o0, ones;

    tbl[0] = '{300, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00};
    tbl[1] = '{480, 0, 8'h00, 8'h00, 1, 0, 0, 8'h00};
    tbl[2] = '{480, 1, 8'h33, 8'h00, 1, 1, 1, 8'h33};
    tbl[3] = '{480, 2, 8'hCC, 8'h55, 1, 1, 2, 8'h55};
    tbl[4] = '{480, 2, 8'hCC, 8'hBE, 1, 0, 2, 8'hBE};
    scr_exp = '{8'h50, 8'h05, 8'h4B, 8'h46, 8'h7F, 8'hFF, 8'h0C, 8'h10, 8'h1C};

    repeat (3) @(negedge clk);
    check("rst dq_oe", dq_oe, 0);
    check("rst conv_busy", conv_busy, 0);
    check("rst rx_byte", rx_byte, 0);
    check("rst rx_valid", rx_valid, 0);
    check("rst presence", presence, 0);
    check("rst cmd_err", cmd_err, 0);
    rst_n = 1'b1;
    wait_us(5);

    for (int i = 0; i < 5; i++) begin
      p0 = pres_cnt; e0 = err_cnt; r0 = rxv_cnt;
      bus_reset(tbl[i].rst_us);
      wait_us(160);
      if (tbl[i].nwr > 0) write_byte(tbl[i].wr0);
      if (tbl[i].nwr > 1) write_byte(tbl[i].wr1);
      wait_us(10);
      check($sformatf("row%0d presence", i), pres_cnt - p0, tbl[i].exp_pres);
      check($sformatf("row%0d cmd_err", i), err_cnt - e0, tbl[i].exp_err);
      check($sformatf("row%0d rx_valid", i), rxv_cnt - r0, tbl[i].exp_rxv);
      check($sformatf("row%0d rx_byte", i), rx_byte, tbl[i].exp_rx);
    end

    // Presence timing relative to reset release
    p0 = pres_cnt;
    bus_reset(480);
    wait_us(20);  check("pd_wait released", dq_oe, 0);
    wait_us(20);  check("presence low early", dq_oe, 1);
    wait_us(100); check("presence low late", dq_oe, 1);
    wait_us(20);  check("presence released", dq_oe, 0);
    check("presence once", pres_cnt - p0, 1);

    // Full scratchpad read with CRC
    reset_presence();
    r0 = rxv_cnt;
    write_byte(8'hCC);
    write_byte(8'hBE);
    check("scr rx_valid count", rxv_cnt - r0, 2);
    check("scr rx first", rx_log1, 8'hCC);
    check("scr rx second", rx_log0, 8'hBE);
    for (int i = 0; i < 9; i++) begin
      read_byte(rb);
      check($sformatf("scr byte%0d", i), rb, scr_exp[i]);
    end

    // Abort mid-read, then a fresh read starts at byte0
    reset_presence();
    write_byte(8'hCC);
    write_byte(8'hBE);
    for (int i = 0; i < 20; i++) read_bit(b);
    p0 = pres_cnt;
    reset_presence();
    check("abort presence", pres_cnt - p0, 1);
    write_byte(8'hCC);
    write_byte(8'hBE);
    read_byte(rb);
    check("abort restart byte0", rb, 8'h50);

    // Unsupported ROM command: slave goes quiet
    reset_presence();
    e0 = err_cnt;
    write_byte(8'h33);
    check("bad rom cmd_err", err_cnt - e0, 1);
    o0 = oe_cyc; ones = 0;
    for (int i = 0; i < 16; i++) begin
      read_bit(b);
      if (b) ones++;
    end
    check("bad rom dq_oe quiet", oe_cyc - o0, 0);
    check("bad rom reads high", ones, 16);

    // Convert T with read-slot polling
    temp_in = 16'h0191;
    reset_presence();
    write_byte(8'hCC);
    write_byte(8'h44);
    check("conv busy start", conv_busy, 1);
    read_bit(b);  check("conv poll busy", b, 0);
    wait_us(570); check("conv busy 680us", conv_busy, 1);
    wait_us(100); check("conv done 780us", conv_busy, 0);
    read_bit(b);  check("conv poll done", b, 1);
    reset_presence();
    write_byte(8'hCC);
    write_byte(8'hBE);
    read_byte(rb); check("conv temp lsb", rb, 8'h91);
    read_byte(rb); check("conv temp msb", rb, 8'h01);

    // Bus reset does not stop conversion; temp_in latched at the end
    temp_in = 16'h1234;
    reset_presence();
    write_byte(8'hCC);
    write_byte(8'h44);
    bus_reset(480);
    wait_us(100);
    check("conv survives reset", conv_busy, 1);
    temp_in = 16'hFE6F;
    wait_us(160);
    check("conv done after reset", conv_busy, 0);
    write_byte(8'hCC);
    write_byte(8'hBE);
    read_byte(rb); check("late temp lsb", rb, 8'h6F);
    read_byte(rb); check("late temp msb", rb, 8'hFE);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
